spm_serial_mult: RTL and testbench

//  Serial-parallel two's-complement multiplier (SPM). Multiplicand x is applied in parallel and held.

---
 rtl/spm_serial_mult.sv | 43 ++++
 tb/tb_spm_serial_mult.sv | 101 ++++++++++
 2 files changed

// File: rtl/spm_serial_mult.sv
// spm_serial_mult: serial-parallel two's-complement multiplier.
// The multiplicand x is held in parallel. The multiplier y enters one bit per clock, LSB first.
// The product p leaves one bit per clock, LSB first, and is 2*WIDTH bits long.
// Ports: clk clock, rst async active-low reset, clr sync clear (starts a new product),
//        x signed multiplicand, y serial multiplier bit (sign-extended), p serial product bit (registered).
module spm_serial_mult #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] x,
    input  logic             y,
    output logic             p
);
    // The MSB cell negates its stream serially (~pp + 1), so its carry starts at 1.
    localparam logic [WIDTH-1:0] C_INIT = {1'b1, {(WIDTH-1){1'b0}}};
    logic [WIDTH-1:0] s, c, pp, s_nxt, c_nxt;
    always_comb begin
        pp = x & {WIDTH{y}};
        s_nxt = '0;
        c_nxt = '0;
        for (int j = 0; j < WIDTH-1; j++) begin
            s_nxt[j] = pp[j] ^ s[j+1] ^ c[j];
            c_nxt[j] = (pp[j] & s[j+1]) | (pp[j] & c[j]) | (s[j+1] & c[j]);
        end
        s_nxt[WIDTH-1] = ~pp[WIDTH-1] ^ c[WIDTH-1];
        c_nxt[WIDTH-1] = ~pp[WIDTH-1] & c[WIDTH-1];
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s <= '0;
            c <= C_INIT;
        end else if (clr) begin
            s <= '0;
            c <= C_INIT;
        end else begin
            s <= s_nxt;
            c <= c_nxt;
        end
    end
    assign p = s[0];
endmodule

// File: tb/tb_spm_serial_mult.sv
// tb_spm_serial_mult: directed and random checks of the serial-parallel multiplier.
module tb_spm_serial_mult;
    logic clk = 1'b0;
    logic rst, clr, y, p;
    logic [7:0] x;
    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] prod;

    spm_serial_mult #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .clr(clr), .x(x), .y(y), .p(p));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [7:0] xv);
        x = xv;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic shift(input logic yb);
        y = yb;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [7:0] xv, input logic [7:0] yv, output logic [15:0] r);
        start(xv);
        for (int k = 0; k < 16; k++) begin
            shift(k < 8 ? yv[k] : yv[7]);
            r[k] = p;
        end
    endtask

    initial begin
        rst = 1'b0;
        clr = 1'b0;
        x = '0;
        y = 1'b0;
        #3;
        check("reset_p", {31'b0, p}, 32'd0);
        #9;
        rst = 1'b1;
        // case 1: y held 1 means y = -1
        run(8'h0C, 8'hFF, prod);
        check("x12_ym1", {16'b0, prod}, 32'h0000FFF4);
        run(8'd5, 8'd3, prod);
        check("x5_y3", {16'b0, prod}, 32'h0000000F);
        run(8'd127, 8'd127, prod);
        check("max_max", {16'b0, prod}, 32'h00003F01);
        run(8'h80, 8'h80, prod);
        check("min_min", {16'b0, prod}, 32'h00004000);
        run(8'h80, 8'd127, prod);
        check("min_max", {16'b0, prod}, 32'h0000C080);
        // async reset after edge 5 of case 1, where p is 1
        start(8'h0C);
        check("clr_p0", {31'b0, p}, 32'd0);
        for (int k = 0; k < 6; k++) shift(1'b1);
        check("pre_rst_p", {31'b0, p}, 32'd1);
        rst = 1'b0;
        #1;
        check("async_rst_p", {31'b0, p}, 32'd0);
        shift(1'b1);
        check("rst_held_p", {31'b0, p}, 32'd0);
        #2;
        rst = 1'b1;
        run(8'd5, 8'd3, prod);
        check("after_rst_x5_y3", {16'b0, prod}, 32'h0000000F);
        // clr after edge 7 of x=-128, y=127, where p is 1
        start(8'h80);
        for (int k = 0; k < 8; k++) shift(k < 7);
        check("pre_clr_p", {31'b0, p}, 32'd1);
        clr = 1'b1;
        shift(1'b0);
        check("mid_clr_p", {31'b0, p}, 32'd0);
        clr = 1'b0;
        run(8'h80, 8'd127, prod);
        check("after_clr_min_max", {16'b0, prod}, 32'h0000C080);
        // random signed pairs
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] xv, yv;
            logic signed [15:0] e;
            xv = 8'($urandom);
            yv = 8'($urandom);
            e = $signed(xv) * $signed(yv);
            run(xv, yv, prod);
            check("random", {16'b0, prod}, {16'b0, e});
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
